// File: rtl/fetch_pkg.sv
// Shared types and constants for the FETCH sequencer and its tag pipe.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   // Tags carry a PC wide enough for any supported address width; users
   // keep only the low DEPTHI bits.
   localparam int TAG_PC_W    = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic                valid;
      logic [TAG_PC_W-1:0] pc;
   } fetch_tag_t;

endpackage

// File: rtl/fetch_tag_pipe.sv
// Tag shift register that follows each issued address through the
// instruction memory's read latency. A flush empties every stage at once.
module fetch_tag_pipe
   import fetch_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush_i,
   input  fetch_tag_t tag_i,
   output fetch_tag_t tag_o
);

   genvar gi;
   generate
      for (gi = 0; gi < MEM_LAT; gi++) begin : g_stage
         fetch_tag_t stage_q;
         if (gi == 0) begin : g_head
            // First stage captures the tag of the address issued this edge.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)       stage_q <= '0;
               else if (flush_i) stage_q <= '0;
               else              stage_q <= tag_i;
            end
         end else begin : g_body
            // Later stages age the tag by one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)       stage_q <= '0;
               else if (flush_i) stage_q <= '0;
               else              stage_q <= g_stage[gi-1].stage_q;
            end
         end
      end
   endgenerate

   assign tag_o = g_stage[MEM_LAT-1].stage_q;

endmodule

// File: rtl/fetch_sequencer.sv
// FETCH control: owns the PC, tags each fetch through the memory latency,
// and handles replay, redirect/squash, halt and misaligned-redirect faults.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                DEPTHI   = 16,
   parameter int                MEM_LAT  = 2,
   parameter logic [DEPTHI-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   input  logic              dec_ready,
   input  logic              redirect_valid,
   input  logic [DEPTHI-1:0] redirect_pc,
   output logic [DEPTHI-1:0] pc_out,
   output logic              out_valid,
   output logic [DEPTHI-1:0] out_pc,
   output logic [1:0]        state_o,
   output logic              fault,
   output logic              wrapped,
   output logic [31:0]       fetch_count
);

   fetch_state_e      state_q, state_d;
   logic [DEPTHI-1:0] pc_q, pc_d;
   logic              fault_q, fault_d;
   logic              wrapped_q, wrapped_d;
   logic [31:0]       count_q, count_d;
   logic              issue, flush;
   logic [DEPTHI:0]   pc_sum;
   fetch_tag_t        tag_in, tag_out;

   assign pc_sum = {1'b0, pc_q} + (DEPTHI+1)'(INSTR_BYTES);

   // Next-state logic; RUN events are resolved highest priority first.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fault_d   = fault_q;
      wrapped_d = wrapped_q;
      issue     = 1'b0;
      flush     = 1'b0;
      // An instruction taken on a squash edge is still counted.
      count_d   = count_q;
      if (tag_out.valid && dec_ready && (count_q != 32'hFFFF_FFFF))
         count_d = count_q + 32'd1;

      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (halt_req) begin
               state_d = HALT;
               flush   = 1'b1;
            end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
               state_d = FAULT;
               fault_d = 1'b1;
               flush   = 1'b1;
            end else if (redirect_valid) begin
               pc_d  = redirect_pc;
               flush = 1'b1;
            end else if (tag_out.valid && !dec_ready) begin
               // Refetch the stalled instruction rather than buffer it.
               pc_d  = tag_out.pc[DEPTHI-1:0];
               flush = 1'b1;
            end else begin
               issue = 1'b1;
               pc_d  = pc_sum[DEPTHI-1:0];
               if (pc_sum[DEPTHI]) wrapped_d = 1'b1;
            end
         end
         HALT: begin
            if (start) begin
               pc_d    = RESET_PC;
               state_d = RUN;
            end
         end
         FAULT: begin
         end
         default: state_d = IDLE;
      endcase
   end

   // Architectural state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         fault_q   <= 1'b0;
         wrapped_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         fault_q   <= fault_d;
         wrapped_q <= wrapped_d;
         count_q   <= count_d;
      end
   end

   assign tag_in.valid = issue;
   assign tag_in.pc    = TAG_PC_W'(pc_q);

   fetch_tag_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst),
      .flush_i (flush),
      .tag_i   (tag_in),
      .tag_o   (tag_out)
   );

   generate
      if (DEPTHI < TAG_PC_W) begin : g_unused
         logic unused_pc_hi;
         assign unused_pc_hi = ^tag_out.pc[TAG_PC_W-1:DEPTHI];
      end
   endgenerate

   assign pc_out      = pc_q;
   assign out_valid   = tag_out.valid;
   assign out_pc      = tag_out.pc[DEPTHI-1:0];
   assign state_o     = state_q;
   assign fault       = fault_q;
   assign wrapped     = wrapped_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: a queue-based fetch model predicts each presented
// instruction and its arrival cycle; a monitor pops and compares.
module tb_fetch_sequencer;

   localparam int LAT = 2;
   localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

   typedef struct {
      int          arrive;
      logic [15:0] pc;
   } flight_t;

   logic        clk = 1'b0;
   logic        rst, start, halt_req, dec_ready, redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] pc_out, out_pc;
   logic        out_valid, fault, wrapped;
   logic [1:0]  state_o;
   logic [31:0] fetch_count;

   logic        rst_b, start_b, dr_b;
   logic [15:0] pc_out_b, out_pc_b;
   logic        out_valid_b, fault_b, wrapped_b;
   logic [1:0]  state_b;
   logic [31:0] count_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // model state
   int          mstate;
   logic [15:0] m_pc;
   bit          m_fault, m_wrapped, m_ov;
   logic [15:0] m_opc;
   int unsigned m_cnt;
   flight_t     inflight[$];
   flight_t     sb[$];

   always #5 clk = ~clk;

   fetch_sequencer #(.DEPTHI(16), .MEM_LAT(LAT), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .dec_ready(dec_ready), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .pc_out(pc_out), .out_valid(out_valid),
      .out_pc(out_pc), .state_o(state_o), .fault(fault), .wrapped(wrapped),
      .fetch_count(fetch_count));

   fetch_sequencer #(.DEPTHI(16), .MEM_LAT(LAT), .RESET_PC(16'hFFF8)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .halt_req(1'b0),
      .dec_ready(dr_b), .redirect_valid(1'b0), .redirect_pc(16'h0000),
      .pc_out(pc_out_b), .out_valid(out_valid_b), .out_pc(out_pc_b),
      .state_o(state_b), .fault(fault_b), .wrapped(wrapped_b),
      .fetch_count(count_b));

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every presented instruction must match the next prediction.
   always @(posedge clk) begin
      flight_t f;
      #1;
      cyc++;
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got out_pc %0h expected no instruction (cycle %0d)", out_pc, cyc);
         end else begin
            f = sb.pop_front();
            check("out_pc", 32'(out_pc), 32'(f.pc));
            check("arrival_cycle", cyc, f.arrive);
            $display("present cycle=%0d pc=%04h ready=%0b", cyc, out_pc, dec_ready);
         end
      end
   end

   function automatic void model_reset();
      mstate = S_IDLE; m_pc = 16'h0000; m_fault = 0; m_wrapped = 0;
      m_ov = 0; m_opc = 16'h0000; m_cnt = 0;
      inflight.delete();
      sb.delete();
   endfunction

   // One cycle: check registered outputs, drive inputs, predict the edge.
   task automatic step(bit s, bit h, bit dr, bit rv, logic [15:0] rpc);
      int      e;
      flight_t f;
      @(negedge clk);
      check("state_o", 32'(state_o), 32'(mstate));
      check("pc_out", 32'(pc_out), 32'(m_pc));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("fault", 32'(fault), 32'(m_fault));
      check("wrapped", 32'(wrapped), 32'(m_wrapped));
      check("fetch_count", fetch_count, m_cnt);
      start = s; halt_req = h; dec_ready = dr; redirect_valid = rv; redirect_pc = rpc;
      e = cyc + 1;
      if (m_ov && dr && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      case (mstate)
         S_IDLE: if (s) mstate = S_RUN;
         S_RUN: begin
            if (h) begin
               mstate = S_HALT; inflight.delete();
            end else if (rv && (rpc % 4 != 0)) begin
               mstate = S_FAULT; m_fault = 1; inflight.delete();
            end else if (rv) begin
               m_pc = rpc; inflight.delete();
            end else if (m_ov && !dr) begin
               m_pc = m_opc; inflight.delete();
            end else begin
               f.arrive = e + LAT - 1;
               f.pc     = m_pc;
               inflight.push_back(f);
               if (int'(m_pc) + 4 > 65535) m_wrapped = 1;
               m_pc = m_pc + 16'd4;
            end
         end
         S_HALT: if (s) begin mstate = S_RUN; m_pc = 16'h0000; end
         default: ;
      endcase
      m_ov = 0;
      if (inflight.size() > 0 && inflight[0].arrive == e) begin
         f = inflight.pop_front();
         m_ov = 1; m_opc = f.pc;
         sb.push_back(f);
      end
   endtask

   // Reset asserted between edges; tags must drop without waiting for a clock.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 0; start = 0; halt_req = 0; dec_ready = 0; redirect_valid = 0;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_state", 32'(state_o), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1;
   endtask

   logic [15:0] b_pc [5] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004, 16'h0008};
   logic        b_w  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic        b_v  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [15:0] b_op [5] = '{16'h0000, 16'h0000, 16'hFFF8, 16'hFFFC, 16'h0000};
   logic [31:0] b_c  [5] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2};

   initial begin
      logic [15:0] rpc;
      rst = 0; rst_b = 0; start = 0; halt_req = 0; dec_ready = 0;
      redirect_valid = 0; redirect_pc = 0; start_b = 0; dr_b = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1; rst_b = 1;

      // idle hold, then streaming with decode always ready
      repeat (2) step(0, 0, 1, 0, 16'h0);
      step(1, 0, 1, 0, 16'h0);
      repeat (5) step(0, 0, 1, 0, 16'h0);
      // stall decode for three cycles, then accept again
      repeat (3) step(0, 0, 0, 0, 16'h0);
      repeat (6) step(0, 0, 1, 0, 16'h0);
      // aligned redirect squashes in-flight fetches
      step(0, 0, 1, 1, 16'h0040);
      repeat (5) step(0, 0, 1, 0, 16'h0);
      // halt beats a simultaneous redirect, then restart at RESET_PC
      step(0, 1, 1, 1, 16'h0080);
      repeat (3) step(0, 0, 1, 0, 16'h0);
      step(1, 0, 1, 0, 16'h0);
      repeat (6) step(0, 0, 1, 0, 16'h0);

      // randomized traffic with periodic asynchronous resets
      for (int i = 0; i < 400; i++) begin
         if (i % 120 == 119) do_reset();
         rpc = 16'($urandom) & 16'hFFFC;
         if ($urandom_range(0, 9) == 0) rpc = rpc | 16'h0002;
         step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 14) == 0, rpc);
      end

      // misaligned redirect: terminal fault, start has no effect
      do_reset();
      step(1, 0, 1, 0, 16'h0);
      repeat (4) step(0, 0, 1, 0, 16'h0);
      step(0, 0, 1, 1, 16'h0042);
      repeat (4) step(1, 0, 1, 0, 16'h0);
      step(0, 0, 1, 0, 16'h0);
      check("scoreboard_drained", sb.size(), 0);

      // wrap-around instance starting at 0xFFF8
      @(negedge clk);
      start_b = 1; dr_b = 1;
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         check("b_state", 32'(state_b), 32'd1);
         check("b_pc_out", 32'(pc_out_b), 32'(b_pc[j]));
         check("b_wrapped", 32'(wrapped_b), 32'(b_w[j]));
         check("b_out_valid", 32'(out_valid_b), 32'(b_v[j]));
         if (b_v[j]) check("b_out_pc", 32'(out_pc_b), 32'(b_op[j]));
         check("b_fetch_count", count_b, b_c[j]);
         $display("wrap cycle=%0d pc_out=%04h out_valid=%0b", j, pc_out_b, out_valid_b);
         if (j < 4) @(negedge clk);
      end
      #2;
      rst_b = 0;
      #1;
      check("b_async_out_valid", 32'(out_valid_b), 32'd0);
      check("b_async_state", 32'(state_b), 32'd0);
      check("b_async_pc", 32'(pc_out_b), 32'hFFF8);
      check("b_async_wrapped", 32'(wrapped_b), 32'd0);
      check("b_async_count", count_b, 32'd0);
      @(negedge clk);
      rst_b = 1;
      @(negedge clk);
      check("b_post_rst_valid", 32'(out_valid_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block for the byte-addressed instruction memory/field register in FETCH. Owns the program counter and drives the memory's Counter input. Tracks each issued address through the memory's fixed read latency so decode receives a valid/PC tag aligned with Opcode/Reg1/Reg2/Immediate. Handles decode back-pressure by replay, branch/jump redirect with squash, halt, and misalignment faults.

Parameters:
DEPTHI, 16, byte-address width; must match the instruction memory.
MEM_LAT, 2, cycles from pc_out sampled to fields valid at memory outputs (Counter→Instruction→fields).
RESET_PC, 0, first fetch address after start; must be a multiple of 4.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  level; begin fetching from RESET_PC (IDLE/HALT only)
halt_req  in  1  decode accepted a halt; stop and squash younger fetches
dec_ready  in  1  decode accepts the instruction presented this cycle
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  DEPTHI  target byte address
pc_out  out  DEPTHI  address to instruction memory Counter
out_valid  out  1  memory fields this cycle are a live instruction
out_pc  out  DEPTHI  address of the instruction in the fields
state_o  out  2  IDLE=0, RUN=1, HALT=2, FAULT=3
fault  out  1  sticky; misaligned redirect seen
wrapped  out  1  sticky; PC incremented past 2^DEPTHI-4
fetch_count  out  32  accepted instructions (out_valid && dec_ready), saturating

Behaviour:
- Reset (rst=0, async): state IDLE, pc_out=RESET_PC, all tags invalid, out_valid=0, out_pc=0, fault=0, wrapped=0, fetch_count=0.
- Tag pipe: MEM_LAT stages of {valid,pc}. Each edge stage0 <= {issue, pc_out}, stage[i] <= stage[i-1]. out_valid/out_pc = last stage. issue=1 only in RUN with no squash this edge.
- IDLE: pc_out held at RESET_PC, issue=0. start=1 → RUN next edge; first out_valid exactly MEM_LAT cycles after entering RUN with out_pc=RESET_PC.
- RUN, event priority per edge (highest first):
  1. halt_req: → HALT; clear all tags; pc_out held.
  2. redirect_valid, redirect_pc[1:0]!=0: → FAULT; fault<=1; clear tags.
  3. redirect_valid aligned: pc_out<=redirect_pc; clear tags (squash wrong-path fetches).
  4. out_valid && !dec_ready (replay): pc_out<=out_pc; clear tags; re-presents the same instruction MEM_LAT cycles later; repeats while dec_ready stays low.
  5. otherwise: pc_out<=pc_out+4, modulo 2^DEPTHI; on wrap set wrapped.
- halt_req/redirect are ignored unless state is RUN.
- fetch_count increments on out_valid && dec_ready in any state, saturating at 32'hFFFF_FFFF; an instruction accepted on the same edge as a squash still counts.
- HALT: issue=0, pc_out frozen, out_valid=0 after the clear. start=1 → pc_out<=RESET_PC, RUN.
- FAULT: terminal until reset; issue=0; start ignored.
- Reset asserted mid-run: all tags drop immediately; no stale out_valid after reset release.
- No combinational path from inputs to outputs; all outputs registered.

Decomposition:
- Package fetch_pkg: state enum (IDLE, RUN, HALT, FAULT), tag struct {valid, pc}, constant INSTR_BYTES=4.
- Sub-module fetch_tag_pipe: MEM_LAT-deep tag shift register with synchronous flush input and async active-low reset.

Test Plan:
- Reset, start=1, dec_ready=1 → pc_out 0,4,8,…; out_valid first high 2 cycles after RUN, out_pc 0,4,8 aligned with memory fields; fetch_count increments each cycle.
- dec_ready low for 3 cycles while out_pc=0x0008 → pc_out rewinds to 0x0008; out_pc=0x0008 re-presented until accepted; no address skipped or duplicated in accepted stream.
- redirect_valid with redirect_pc=0x0040 while 0x000C,0x0010 in flight → both squashed (out_valid=0 two cycles), next out_pc=0x0040.
- redirect_pc=0x0042 → state_o=3, fault=1, out_valid stays 0; start ignored until rst low.
- halt_req with simultaneous redirect → HALT wins, no redirect; start → resumes at RESET_PC.
- RESET_PC=0xFFF8, run 3 fetches → pc_out 0xFFF8, 0xFFFC, 0x0000; wrapped=1; async rst mid-stream → out_valid 0 immediately.
